// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// requester ids and the default memory depth.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic        REQ_ID0       = 1'b0;
    localparam logic        REQ_ID1       = 1'b1;
    localparam int unsigned NUM_REQ       = 2;
    localparam int          DEFAULT_DEPTH = 32;

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// Combinational two-way picker. Define DMEM_ARB_RR_EN for round-robin tie
// breaking; otherwise requester 0 always wins a tie.
module dmem_arb_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = REQ_ID0;
        if (req_i == 2'b10) begin
            winner_o = REQ_ID1;
        end else if (req_i == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            winner_o = ~last_grant_i;
`else
            winner_o = REQ_ID0;
`endif
        end
    end

`ifndef DMEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory.
// Tie policy is selected inside dmem_arb_pick2 by the DMEM_ARB_RR_EN macro.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_gnt_o,
    output logic              r0_ack_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic              r0_err_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_gnt_o,
    output logic              r1_ack_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic              r1_err_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_e            state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oob_q, oob_d;
    logic              last_grant_q, last_grant_d;

    logic              pick_id, pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [NUM_REQ-1:0] gnt_vec, ack_vec, err_vec;
    logic [DATA_W-1:0]  rdata_resp;
    logic [DATA_W-1:0]  rdata_vec [NUM_REQ];

    dmem_arb_pick2 u_pick (
        .req_i       ({r1_req_i, r0_req_i}),
        .last_grant_i(last_grant_q),
        .winner_o    (pick_id),
        .valid_o     (pick_valid)
    );

    assign sel_we    = pick_id ? r1_we_i    : r0_we_i;
    assign sel_addr  = pick_id ? r1_addr_i  : r0_addr_i;
    assign sel_wdata = pick_id ? r1_wdata_i : r0_wdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            id_q         <= REQ_ID0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            oob_q        <= 1'b0;
            // Reset to requester 1 so requester 0 wins the first tie.
            last_grant_q <= REQ_ID1;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            oob_q        <= oob_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        oob_d        = oob_q;
        last_grant_d = last_grant_q;
        mem_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        gnt_vec      = '0;
        ack_vec      = '0;
        err_vec      = '0;
        rdata_resp   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d    = pick_id;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    oob_d   = (sel_addr >= DEPTH_A);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                gnt_vec[id_q] = 1'b1;
                mem_write_o   = !oob_q && we_q;
                mem_read_o    = !oob_q && !we_q;
                last_grant_d  = id_q;
                state_d       = RESP;
            end
            RESP: begin
                ack_vec[id_q] = 1'b1;
                err_vec[id_q] = oob_q;
                // The memory registered its read data at the edge ending ACCESS.
                if (!we_q && !oob_q) begin
                    rdata_resp = mem_data_i;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdata
            assign rdata_vec[gi] = ack_vec[gi] ? rdata_resp : '0;
        end
    endgenerate

    assign r0_gnt_o   = gnt_vec[0];
    assign r1_gnt_o   = gnt_vec[1];
    assign r0_ack_o   = ack_vec[0];
    assign r1_ack_o   = ack_vec[1];
    assign r0_err_o   = err_vec[0];
    assign r1_err_o   = err_vec[1];
    assign r0_rdata_o = rdata_vec[0];
    assign r1_rdata_o = rdata_vec[1];
    assign mem_addr_o = addr_q;
    assign mem_data_o = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a registered-read 32-word memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        r0_req_i, r0_we_i, r1_req_i, r1_we_i;
    logic [31:0] r0_addr_i, r0_wdata_i, r1_addr_i, r1_wdata_i;
    logic        r0_gnt_o, r0_ack_o, r0_err_o, r1_gnt_o, r1_ack_o, r1_err_o;
    logic [31:0] r0_rdata_o, r1_rdata_o;
    logic        mem_write_o, mem_read_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .r0_req_i(r0_req_i), .r0_we_i(r0_we_i), .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i),
        .r0_gnt_o(r0_gnt_o), .r0_ack_o(r0_ack_o), .r0_rdata_o(r0_rdata_o), .r0_err_o(r0_err_o),
        .r1_req_i(r1_req_i), .r1_we_i(r1_we_i), .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i),
        .r1_gnt_o(r1_gnt_o), .r1_ack_o(r1_ack_o), .r1_rdata_o(r1_rdata_o), .r1_err_o(r1_err_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    // Memory model: write and registered read at the clock edge.
    logic [31:0] mem_arr [32];
    logic [31:0] mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (mem_write_o) mem_arr[mem_addr_o[4:0]] <= mem_data_o;
        if (mem_read_o)  mem_rdata <= mem_arr[mem_addr_o[4:0]];
    end
    assign mem_data_i = mem_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   exp_gnt_q[$];
    int   ack_cyc_q[$];
    int   n_pass = 0, n_total = 0;
    int   cyc = 0, wr_cnt = 0, rd_cnt = 0;
    exp_t mon_e;
    int   mon_g;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops grant order and per-requester responses when the DUT presents them.
    always @(negedge clk) begin
        if (mem_write_o) wr_cnt++;
        if (mem_read_o)  rd_cnt++;
        if (r0_gnt_o || r1_gnt_o) begin
            if (exp_gnt_q.size() == 0) check("gnt_unexpected", {62'b0, r1_gnt_o, r0_gnt_o}, 64'h0);
            else begin
                mon_g = exp_gnt_q.pop_front();
                check("gnt_id", {62'b0, r1_gnt_o, r0_gnt_o}, (mon_g == 1) ? 64'h2 : 64'h1);
            end
        end
        if (r0_ack_o) begin
            ack_cyc_q.push_back(cyc);
            if (exp_q0.size() == 0) check("ack0_unexpected", 64'h1, 64'h0);
            else begin
                mon_e = exp_q0.pop_front();
                check("ack0_err", {63'b0, r0_err_o}, {63'b0, mon_e.err});
                check("ack0_rdata", {32'b0, r0_rdata_o}, {32'b0, mon_e.rdata});
                $display("txn r0 ack err=%0d rdata=0x%08h cycle=%0d", r0_err_o, r0_rdata_o, cyc);
            end
        end
        if (r1_ack_o) begin
            ack_cyc_q.push_back(cyc);
            if (exp_q1.size() == 0) check("ack1_unexpected", 64'h1, 64'h0);
            else begin
                mon_e = exp_q1.pop_front();
                check("ack1_err", {63'b0, r1_err_o}, {63'b0, mon_e.err});
                check("ack1_rdata", {32'b0, r1_rdata_o}, {32'b0, mon_e.rdata});
                $display("txn r1 ack err=%0d rdata=0x%08h cycle=%0d", r1_err_o, r1_rdata_o, cyc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {56'b0, r0_gnt_o, r1_gnt_o, r0_ack_o, r1_ack_o,
                              r0_err_o, r1_err_o, mem_write_o, mem_read_o}, 64'h0);
        check({tag, "_addr_data"}, {mem_addr_o, mem_data_o}, 64'h0);
        check({tag, "_rdata"}, {r0_rdata_o, r1_rdata_o}, 64'h0);
    endtask

    // Issue one transaction and hold it until its ack; call at posedge+1.
    task automatic do_txn(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        bit   got;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        if (id == 0) begin
            exp_q0.push_back(e);
            r0_we_i = we; r0_addr_i = addr; r0_wdata_i = wdata; r0_req_i = 1'b1;
        end else begin
            exp_q1.push_back(e);
            r1_we_i = we; r1_addr_i = addr; r1_wdata_i = wdata; r1_req_i = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? r0_ack_o : r1_ack_o;
        end
        if (!got) check("ack_timeout", 64'h0, 64'h1);
        @(posedge clk); #1;
        if (id == 0) r0_req_i = 1'b0;
        else         r1_req_i = 1'b0;
    endtask

    task automatic solo(input int id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        exp_gnt_q.push_back(id);
        do_txn(id, we, addr, wdata, exp_err, exp_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, s1, a0;
        rst_i = 1'b1;
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 32'd1; r0_wdata_i = 32'h11;
        r1_req_i = 1'b1; r1_we_i = 1'b1; r1_addr_i = 32'd2; r1_wdata_i = 32'h22;

        // Reset held for 3 cycles with both requests high.
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        @(posedge clk); #1;
        rst_i = 1'b0; r0_req_i = 1'b0; r1_req_i = 1'b0;
        idle(1);

        // Single write with cycle-accurate strobe checks.
        exp_gnt_q.push_back(0);
        exp_q0.push_back('{err: 1'b0, rdata: 32'h0});
        r0_we_i = 1'b1; r0_addr_i = 32'd5; r0_wdata_i = 32'hDEADBEEF; r0_req_i = 1'b1;
        @(negedge clk);
        check("t1_idle_strobes", {62'b0, mem_write_o, mem_read_o}, 64'h0);
        @(negedge clk);
        check("t1_access_strobes", {61'b0, mem_write_o, mem_read_o, r0_gnt_o}, 64'h5);
        check("t1_access_addr_data", {mem_addr_o, mem_data_o}, {32'd5, 32'hDEADBEEF});
        @(negedge clk);
        check("t1_resp_ack", {62'b0, r0_ack_o, mem_write_o}, 64'h2);
        @(posedge clk); #1;
        r0_req_i = 1'b0;
        solo(0, 1'b0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF);

        // Out-of-range and address boundaries; mem_data_i still holds 0xDEADBEEF.
        s0 = wr_cnt + rd_cnt;
        solo(1, 1'b0, 32'd40, 32'h0, 1'b1, 32'h0);
        idle(1);
        check("oob_no_strobe", 64'(wr_cnt + rd_cnt - s0), 64'h0);
        solo(0, 1'b1, 32'd31, 32'h1234, 1'b0, 32'h0);
        solo(0, 1'b0, 32'd31, 32'h0, 1'b0, 32'h1234);
        solo(0, 1'b0, 32'd32, 32'h0, 1'b1, 32'h0);
        solo(0, 1'b1, 32'h8000_0005, 32'h5555, 1'b1, 32'h0);
        solo(0, 1'b0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF);

        // Continuous tie right after reset.
        rst_i = 1'b1; idle(1); rst_i = 1'b0;
`ifdef DMEM_ARB_RR_EN
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
`else
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(0);
        exp_gnt_q.push_back(1); exp_gnt_q.push_back(1);
`endif
        ack_cyc_q.delete();
        fork
            begin
                do_txn(0, 1'b1, 32'd10, 32'hA0, 1'b0, 32'h0);
                do_txn(0, 1'b1, 32'd11, 32'hA1, 1'b0, 32'h0);
            end
            begin
                do_txn(1, 1'b1, 32'd20, 32'hB0, 1'b0, 32'h0);
                do_txn(1, 1'b1, 32'd21, 32'hB1, 1'b0, 32'h0);
            end
        join
        check("tie_ack_count", 64'(ack_cyc_q.size()), 64'd4);
        if (ack_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("tie_ack_spacing", 64'(ack_cyc_q[i] - ack_cyc_q[i-1]), 64'd3);
        end
        solo(0, 1'b0, 32'd10, 32'h0, 1'b0, 32'hA0);
        solo(1, 1'b0, 32'd11, 32'h0, 1'b0, 32'hA1);
        solo(0, 1'b0, 32'd20, 32'h0, 1'b0, 32'hB0);
        solo(1, 1'b0, 32'd21, 32'h0, 1'b0, 32'hB1);

        // Requester drops req (and scrambles fields) during ACCESS.
        s1 = wr_cnt;
        exp_gnt_q.push_back(1);
        exp_q1.push_back('{err: 1'b0, rdata: 32'h0});
        r1_we_i = 1'b1; r1_addr_i = 32'd7; r1_wdata_i = 32'h77; r1_req_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        r1_req_i = 1'b0; r1_addr_i = 32'd9; r1_wdata_i = 32'h0;
        @(negedge clk);
        check("drop_access", {31'b0, mem_write_o, mem_addr_o}, {31'b0, 1'b1, 32'd7});
        @(negedge clk);
        check("drop_ack", {63'b0, r1_ack_o}, 64'h1);
        idle(2);
        check("drop_one_write", 64'(wr_cnt - s1), 64'd1);
        solo(1, 1'b0, 32'd7, 32'h0, 1'b0, 32'h77);

        // Reset during ACCESS: transaction dropped with no ack.
        exp_gnt_q.push_back(0);
        r0_we_i = 1'b1; r0_addr_i = 32'd3; r0_wdata_i = 32'h33; r0_req_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1; r0_req_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_i = 1'b0;
        a0 = ack_cyc_q.size();
        @(negedge clk);
        check_all_zero("midop_reset");
        idle(4);
        check("midop_no_ack", 64'(ack_cyc_q.size() - a0), 64'h0);
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
        fork
            do_txn(0, 1'b0, 32'd10, 32'h0, 1'b0, 32'hA0);
            do_txn(1, 1'b0, 32'd20, 32'h0, 1'b0, 32'hB0);
        join

        idle(3);
        check("q0_drained", 64'(exp_q0.size()), 64'h0);
        check("q1_drained", 64'(exp_q1.size()), 64'h0);
        check("gnt_drained", 64'(exp_gnt_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
